ian_routine_scheduler: RTL and testbench
========================================

// Module: ian_routine_scheduler
// PURPOSE
//  Arbiter/sequencer in front of the iankim condition tracker. Takes level requests for
//  food, iced coffee and sleep, plus the tracker's current condition (0..100), and
//  drives the tracker's sleep / Food / Iced_coffee inputs. Outputs are one-hot.
//  Enforces an auto-sleep threshold, a minimum sleep length, a coffee cooldown and a
//  per-wake coffee limit.
// PARAMETERS
//  SLEEP_THRESH    10  condition <= this in AWAKE forces sleep
//  SLEEP_CYCLES    8   cycles sleep is held high per sleep period (>=1)
//  COFFEE_COOLDOWN 5   cooldown loaded on each coffee grant
//  MAX_COFFEE      3   coffee grants allowed per wake period
//  CNT_W           8   width of the internal sleep and cooldown counters
// PORTS
//  CLK           in   1  clock, all state on rising edge
//  RST_n         in   1  asynchronous reset, active-low
//  condition     in   7  tracker value; >100 is treated as 100
//  food_req      in   1  level request for food
//  coffee_req    in   1  level request for iced coffee
//  sleep_req     in   1  level request for sleep
//  sleep         out  1  to tracker; high for whole sleep period
//  Food          out  1  to tracker; one-cycle grant
//  Iced_coffee   out  1  to tracker; one-cycle grant
//  coffee_denied out  1  one-cycle pulse: coffee request rejected
//  state         out  2  00 AWAKE, 01 SLEEPING, 10 WAKE
//  coffee_count  out  2  coffee grants this wake period (0..MAX_COFFEE)
// BEHAVIOUR
//  - Reset (RST_n low, async): state=AWAKE; sleep, Food, Iced_coffee, coffee_denied=0;
//    coffee_count=0; sleep and cooldown counters=0. Held while RST_n low.
//  - All outputs registered; a request sampled at edge t gives its output after edge t.
//  - At most one of sleep/Food/Iced_coffee high in any cycle.
//  - AWAKE, per edge, first match wins:
//    1 sleep_req or cond<=SLEEP_THRESH -> SLEEPING; sleep=1; sleep ctr=SLEEP_CYCLES-1.
//    2 food_req -> Food=1 for one cycle. A pending coffee_req is held, not denied.
//    3 coffee_req, cooldown==0, coffee_count<MAX_COFFEE and cond<100
//      -> Iced_coffee=1 for one cycle; coffee_count+1; cooldown=COFFEE_COOLDOWN.
//    4 coffee_req otherwise -> coffee_denied=1 for one cycle.
//    5 Otherwise all grant outputs 0.
//  - Cooldown decrements once per edge while nonzero, in every state. A grant checks
//    the value before the edge, so held-request grants are COFFEE_COOLDOWN+1 edges apart.
//  - SLEEPING: sleep=1. All requests are ignored: no grants and no denials.
//    Sleep ctr decrements each edge; at edge where ctr==0 -> WAKE, sleep=0.
//    sleep is therefore high for exactly SLEEP_CYCLES cycles.
//  - WAKE (one cycle): all grant outputs 0; coffee_count=0; cooldown=0; next -> AWAKE.
//    Requests are ignored in WAKE.
//  - A condition still <= SLEEP_THRESH on return to AWAKE re-enters SLEEPING.
//  - coffee_count saturates at MAX_COFFEE and never wraps.
// TESTING
//  1 RST_n low during SLEEPING (cycle 3 of 8) -> sleep=0, state=00 immediately,
//    before any clock edge; after release with no requests, all outputs stay 0.
//  2 cond=50, coffee_req held high -> Iced_coffee pulses at edges 0, 6, 12;
//    edge 18 gives coffee_denied=1 and coffee_count=3.
//  3 cond=50, food_req=coffee_req=1 at the same edge -> Food=1, Iced_coffee=0,
//    coffee_denied=0. Drop food_req and coffee is granted at the next edge.
//  4 cond=10 with no requests -> sleep high for 8 cycles, then one WAKE cycle
//    (coffee_count=0), then AWAKE. If cond is still 10, sleep is reasserted.
//  5 sleep_req pulse, then food_req+coffee_req during SLEEPING and WAKE
//    -> Food, Iced_coffee and coffee_denied all stay 0.
//  6 cond=100 or cond=127 with coffee_req -> coffee_denied=1 and count unchanged;
//    cond=99 -> Iced_coffee=1.

Source files
------------

// File: rtl/ian_routine_scheduler.sv
// Routine arbiter in front of the condition tracker: sleep / food / iced-coffee sequencing.
// Latency: one cycle. A request sampled at edge t shows on the registered outputs after edge t.
// Backpressure: none. Requests are levels. Coffee blocked by food is held; requests during sleep and wake are dropped.
module ian_routine_scheduler #(
  parameter int SLEEP_THRESH    = 10,
  parameter int SLEEP_CYCLES    = 8,
  parameter int COFFEE_COOLDOWN = 5,
  parameter int MAX_COFFEE      = 3,
  parameter int CNT_W           = 8
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [6:0] condition,
  input  logic       food_req,
  input  logic       coffee_req,
  input  logic       sleep_req,
  output logic       sleep,
  output logic       Food,
  output logic       Iced_coffee,
  output logic       coffee_denied,
  output logic [1:0] state,
  output logic [1:0] coffee_count
);

  typedef enum logic [1:0] {
    ST_AWAKE    = 2'b00,
    ST_SLEEPING = 2'b01,
    ST_WAKE     = 2'b10
  } state_t;

  localparam logic [6:0]       L_THRESH     = 7'(SLEEP_THRESH);
  localparam logic [6:0]       L_FULL       = 7'd100;
  localparam logic [CNT_W-1:0] L_SLEEP_LOAD = CNT_W'(SLEEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_COOL_LOAD  = CNT_W'(COFFEE_COOLDOWN);
  localparam logic [1:0]       L_MAX_COFFEE = 2'(MAX_COFFEE);

  state_t           r_state;
  logic             r_sleep;
  logic             r_food;
  logic             r_coffee;
  logic             r_denied;
  logic [1:0]       r_coffee_count;
  logic [CNT_W-1:0] r_sleep_ctr;
  logic [CNT_W-1:0] r_cooldown;

  logic [6:0]       w_cond;
  logic [CNT_W-1:0] w_cool_dec;
  logic             w_go_sleep;
  logic             w_coffee_ok;

  // Clamp the tracker value, then derive the decision terms used by the AWAKE arbitration.
  always_comb begin
    w_cond      = (condition > L_FULL) ? L_FULL : condition;
    w_cool_dec  = (r_cooldown != '0) ? (r_cooldown - 1'b1) : '0;
    w_go_sleep  = sleep_req || (w_cond <= L_THRESH);
    w_coffee_ok = (r_cooldown == '0) && (r_coffee_count < L_MAX_COFFEE) && (w_cond < L_FULL);
  end

  // Single FSM: state, sleep and cooldown counters, and all registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state        <= ST_AWAKE;
      r_sleep        <= 1'b0;
      r_food         <= 1'b0;
      r_coffee       <= 1'b0;
      r_denied       <= 1'b0;
      r_coffee_count <= 2'd0;
      r_sleep_ctr    <= '0;
      r_cooldown     <= '0;
    end else begin
      // Grants are single-cycle pulses; the cooldown keeps draining in every state
      // unless a grant or the wake cycle overrides it below.
      r_food     <= 1'b0;
      r_coffee   <= 1'b0;
      r_denied   <= 1'b0;
      r_cooldown <= w_cool_dec;

      case (r_state)
        ST_AWAKE: begin
          if (w_go_sleep) begin
            r_state     <= ST_SLEEPING;
            r_sleep     <= 1'b1;
            r_sleep_ctr <= L_SLEEP_LOAD;
          end else if (food_req) begin
            // Food wins; a simultaneous coffee request stays pending, not denied.
            r_food <= 1'b1;
          end else if (coffee_req) begin
            if (w_coffee_ok) begin
              r_coffee       <= 1'b1;
              r_coffee_count <= r_coffee_count + 2'd1;
              r_cooldown     <= L_COOL_LOAD;
            end else begin
              r_denied <= 1'b1;
            end
          end
        end

        ST_SLEEPING: begin
          // sleep is already high from entry; stays high until the counter expires.
          if (r_sleep_ctr == '0) begin
            r_state        <= ST_WAKE;
            r_sleep        <= 1'b0;
            r_coffee_count <= 2'd0;
            r_cooldown     <= '0;
          end else begin
            r_sleep_ctr <= r_sleep_ctr - 1'b1;
          end
        end

        ST_WAKE: begin
          // One quiet cycle that starts a fresh wake period.
          r_state        <= ST_AWAKE;
          r_sleep        <= 1'b0;
          r_coffee_count <= 2'd0;
          r_cooldown     <= '0;
        end

        default: begin
          r_state <= ST_AWAKE;
          r_sleep <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    sleep         = r_sleep;
    Food          = r_food;
    Iced_coffee   = r_coffee;
    coffee_denied = r_denied;
    state         = r_state;
    coffee_count  = r_coffee_count;
  end

endmodule

// File: tb/tb_ian_routine_scheduler.sv
// Bench for ian_routine_scheduler: directed scenarios followed by randomized traffic.
// Latency: outputs compared 1ns after each rising edge against a behavioural model.
// Backpressure: none; the model drops requests during sleep and wake.
module tb_ian_routine_scheduler;

  logic       CLK;
  logic       RST_n;
  logic [6:0] condition;
  logic       food_req;
  logic       coffee_req;
  logic       sleep_req;
  logic       sleep;
  logic       Food;
  logic       Iced_coffee;
  logic       coffee_denied;
  logic [1:0] state;
  logic [1:0] coffee_count;

  int checks = 0;
  int errors = 0;

  ian_routine_scheduler dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .condition    (condition),
    .food_req     (food_req),
    .coffee_req   (coffee_req),
    .sleep_req    (sleep_req),
    .sleep        (sleep),
    .Food         (Food),
    .Iced_coffee  (Iced_coffee),
    .coffee_denied(coffee_denied),
    .state        (state),
    .coffee_count (coffee_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model. Phase: 0 awake, 1 asleep, 2 wake. Sleep is tracked as remaining
  // high cycles; coffee spacing as the edge number of the last grant.
  int m_phase;
  int m_sleep_left;
  int m_count;
  int m_last_grant;
  int m_edge;
  bit e_sleep, e_food, e_coffee, e_denied;

  task automatic model_reset();
    m_phase      = 0;
    m_sleep_left = 0;
    m_count      = 0;
    m_last_grant = -1000;
    e_sleep = 0; e_food = 0; e_coffee = 0; e_denied = 0;
  endtask

  task automatic model_edge(input int cond, input bit f, input bit c, input bit s);
    int cc;
    cc = (cond > 100) ? 100 : cond;
    m_edge++;
    e_food = 0; e_coffee = 0; e_denied = 0;
    if (m_phase == 0) begin
      if (s || cc <= 10) begin
        m_phase = 1; e_sleep = 1; m_sleep_left = 8;
      end else if (f) begin
        e_food = 1;
      end else if (c) begin
        if ((m_edge - m_last_grant) >= 6 && m_count < 3 && cc < 100) begin
          e_coffee = 1; m_count++; m_last_grant = m_edge;
        end else begin
          e_denied = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_sleep_left--;
      if (m_sleep_left == 0) begin
        m_phase = 2; e_sleep = 0; m_count = 0; m_last_grant = -1000;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {state, coffee_count, sleep, Food, Iced_coffee, coffee_denied};
  endfunction

  function automatic logic [7:0] model_vec();
    return {m_phase[1:0], m_count[1:0], e_sleep, e_food, e_coffee, e_denied};
  endfunction

  // Drive one set of inputs across one rising edge and compare the whole output vector.
  task automatic step(input int cond, input bit f, input bit c, input bit s, input string tag);
    condition  = 7'(cond);
    food_req   = f;
    coffee_req = c;
    sleep_req  = s;
    @(posedge CLK);
    model_edge(cond, f, c, s);
    #1;
    check(tag, 32'(dut_vec()), 32'(model_vec()));
    check({tag, "_onehot"}, 32'($countones({sleep, Food, Iced_coffee}) <= 1), 32'd1);
  endtask

  initial begin
    int rc, rf, rcf, rs;
    m_edge     = 0;
    RST_n      = 1'b0;
    condition  = 7'd50;
    food_req   = 1'b0;
    coffee_req = 1'b0;
    sleep_req  = 1'b0;
    model_reset();
    #1;
    check("reset_state", 32'(dut_vec()), 32'd0);
    #21;
    RST_n = 1'b1;

    // 1: async reset in the middle of a sleep period.
    step(50, 0, 0, 1, "t1_enter");
    step(50, 0, 0, 0, "t1_sleep2");
    step(50, 0, 0, 0, "t1_sleep3");
    check("t1_sleep_high", 32'(sleep), 32'd1);
    RST_n = 1'b0;
    #1;
    model_reset();
    check("t1_async_clear", 32'(dut_vec()), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("t1_held", 32'(dut_vec()), 32'd0);
    RST_n = 1'b1;
    for (int i = 0; i < 4; i++) step(50, 0, 0, 0, "t1_idle");

    // 2: held coffee request, cooldown spacing and per-wake limit.
    for (int k = 0; k <= 18; k++) begin
      step(50, 0, 1, 0, "t2_model");
      if (k == 0 || k == 6 || k == 12) check("t2_grant", 32'(Iced_coffee), 32'd1);
      if (k == 18) begin
        check("t2_denied", 32'(coffee_denied), 32'd1);
        check("t2_count", 32'(coffee_count), 32'd3);
      end
    end

    // 5: requests during sleeping and wake are ignored.
    step(50, 0, 0, 1, "t5_enter");
    for (int i = 0; i < 9; i++) begin
      step(50, 1, 1, 0, "t5_model");
      check("t5_quiet", 32'({Food, Iced_coffee, coffee_denied}), 32'd0);
    end
    step(50, 0, 0, 0, "t5_idle");

    // 3: food beats coffee, pending coffee granted next edge.
    step(50, 1, 1, 0, "t3_both");
    check("t3_food", 32'({Food, Iced_coffee, coffee_denied}), 32'b100);
    step(50, 0, 1, 0, "t3_coffee");
    check("t3_coffee_grant", 32'(Iced_coffee), 32'd1);

    // 6: full condition denies coffee; 99 allows it once cooldown drains.
    step(100, 0, 1, 0, "t6_c100");
    check("t6_den100", 32'({coffee_denied, coffee_count}), 32'b101);
    step(127, 0, 1, 0, "t6_c127");
    check("t6_den127", 32'({coffee_denied, coffee_count}), 32'b101);
    for (int i = 0; i < 5; i++) step(50, 0, 0, 0, "t6_idle");
    step(99, 0, 1, 0, "t6_c99");
    check("t6_grant99", 32'({Iced_coffee, coffee_count}), 32'b110);

    // 4: auto-sleep at threshold, exact sleep length, wake cycle, re-entry.
    step(10, 0, 0, 0, "t4_enter");
    check("t4_sleep_on", 32'({state, sleep}), 32'b011);
    for (int i = 1; i < 8; i++) begin
      step(10, 0, 0, 0, "t4_model");
      check("t4_sleep_held", 32'(sleep), 32'd1);
    end
    step(10, 0, 0, 0, "t4_wake");
    check("t4_wake_state", 32'({state, coffee_count, sleep}), 32'b10000);
    step(10, 0, 0, 0, "t4_awake");
    check("t4_awake_state", 32'({state, sleep}), 32'b000);
    step(10, 0, 0, 0, "t4_reenter");
    check("t4_resleep", 32'({state, sleep}), 32'b011);
    for (int i = 0; i < 10; i++) step(50, 0, 0, 0, "t4_drain");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rc  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 127));
      rf  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rcf = int'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 24) == 0) ? 1 : 0;
      step(rc, rf[0], rcf[0], rs[0], "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
